dram_seq: RTL and testbench

DRAM cycle sequencer for the memory controller. It accepts single-word read/write requests for one of two banks and sequences the row/column phases. It schedules CAS-before-RAS refresh and keeps a page open between accesses. Its outputs drive the per-bank RAS chip-select generators through the on/off strobes (on, roffl, allonl, alloffl), the shared CAS strobe and the row/column address mux.

---
 rtl/dram_seq.sv | 170 +++++++++++++++++
 tb/tb_dram_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dram_seq.sv
// dram_seq: DRAM cycle sequencer for one two-bank memory controller.
// Takes single-word read/write requests, sequences RAS/CAS phases, keeps a
// page open between accesses (PAGE=1) and inserts CAS-before-RAS refresh.
//
// Ports
//   clk, res           clock, synchronous active-high reset
//   req/write/bank/row request (held until ack), direction, bank, row
//   ack                one-cycle pulse on the last CAS cycle
//   busy               high whenever not IDLE
//   on[1:0]            one-hot RAS-on strobe for the opened bank
//   roffl              active-low RAS-off strobe for the open bank
//   allonl/alloffl     active-low all-bank RAS on/off strobes (refresh)
//   casl, colsel, wel  CAS, row/column address mux, write enable
module dram_seq #(
   parameter int TRCD   = 2,
   parameter int TCAS   = 2,
   parameter int TRP    = 2,
   parameter int TRAS   = 3,
   parameter int REFDIV = 256,
   parameter bit PAGE   = 1'b1
) (
   input  logic       clk,
   input  logic       res,
   input  logic       req,
   input  logic       write,
   input  logic       bank,
   input  logic [8:0] row,
   output logic       ack,
   output logic       busy,
   output logic [1:0] on,
   output logic       roffl,
   output logic       allonl,
   output logic       alloffl,
   output logic       casl,
   output logic       colsel,
   output logic       wel
);

   localparam int MAXP = (TRCD > TCAS ? TRCD : TCAS) > (TRP > TRAS ? TRP : TRAS) ?
                         (TRCD > TCAS ? TRCD : TCAS) : (TRP > TRAS ? TRP : TRAS);
   localparam int CW = $clog2(MAXP + 1);
   localparam int RW = $clog2(REFDIV);

   typedef enum logic [2:0] {IDLE, PRE, ROW, RCD, CAS, RCAS, RRAS, RPRE} state_t;
   // Where a precharge goes when it finishes.
   typedef enum logic [1:0] {PX_ROW, PX_RCAS, PX_IDLE} pre_exit_t;

   state_t         state, nxt;
   pre_exit_t      pre_exit, pre_exit_d;
   logic [CW-1:0]  cnt;
   logic [RW-1:0]  ref_cnt;
   logic           pending, page_open, open_bank, lat_write, lat_bank, accept;
   logic [8:0]     open_row, lat_row;
   logic           last, ref_tc;

   // Phase-counter load value: cycles spent in the state, minus one.
   function automatic logic [CW-1:0] ld(input state_t s);
      case (s)
         PRE, RPRE: ld = CW'(TRP - 1);
         RCD:       ld = CW'(TRCD - 1);
         CAS:       ld = CW'(TCAS - 1);
         RRAS:      ld = CW'(TRAS - 1);
         default:   ld = '0;
      endcase
   endfunction

   assign last   = (cnt == '0);
   assign ref_tc = (ref_cnt == RW'(REFDIV - 1));

   always_comb begin
      nxt        = state;
      pre_exit_d = pre_exit;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               // refresh beats a simultaneous request; req stays held
               if (page_open) begin
                  nxt        = PRE;
                  pre_exit_d = PX_RCAS;
               end else begin
                  nxt = RCAS;
               end
            end else if (req) begin
               accept = 1'b1;
               if (page_open && bank == open_bank && row == open_row) begin
                  nxt = CAS;
               end else if (page_open) begin
                  nxt        = PRE;
                  pre_exit_d = PX_ROW;
               end else begin
                  nxt = ROW;
               end
            end
         end
         PRE: if (last) begin
            case (pre_exit)
               PX_RCAS: nxt = RCAS;
               PX_IDLE: nxt = IDLE;
               default: nxt = ROW;
            endcase
         end
         ROW:  nxt = RCD;
         RCD:  if (last) nxt = CAS;
         CAS:  if (last) begin
            if (PAGE) begin
               nxt = IDLE;
            end else begin
               // closed-page mode: precharge right after the access
               nxt        = PRE;
               pre_exit_d = PX_IDLE;
            end
         end
         RCAS: nxt = RRAS;
         RRAS: if (last) nxt = RPRE;
         RPRE: if (last) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state     <= IDLE;
         pre_exit  <= PX_ROW;
         cnt       <= '0;
         ref_cnt   <= '0;
         pending   <= 1'b0;
         page_open <= 1'b0;
         open_bank <= 1'b0;
         open_row  <= '0;
         lat_write <= 1'b0;
         lat_bank  <= 1'b0;
         lat_row   <= '0;
      end else begin
         state    <= nxt;
         pre_exit <= pre_exit_d;
         if (nxt != state)  cnt <= ld(nxt);
         else if (!last)    cnt <= cnt - 1'b1;

         ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
         // saturating: a terminal count while pending is simply absorbed
         if (ref_tc)              pending <= 1'b1;
         else if (state == RCAS)  pending <= 1'b0;

         if (accept) begin
            lat_write <= write;
            lat_bank  <= bank;
            lat_row   <= row;
         end
         if (state == ROW) begin
            page_open <= 1'b1;
            open_bank <= lat_bank;
            open_row  <= lat_row;
         end
         if (state == PRE || state == RPRE) page_open <= 1'b0;
      end
   end

   // Moore outputs; first-cycle strobes key off the freshly loaded counter.
   assign ack     = (state == CAS) && last;
   assign busy    = (state != IDLE);
   assign on      = (state == ROW) ? (lat_bank ? 2'b10 : 2'b01) : 2'b00;
   assign roffl   = !((state == PRE)  && cnt == CW'(TRP - 1));
   assign allonl  = !((state == RRAS) && cnt == CW'(TRAS - 1));
   assign alloffl = !((state == RPRE) && cnt == CW'(TRP - 1));
   assign casl    = !(state == CAS || state == RCAS || state == RRAS);
   assign colsel  = (state == CAS);
   assign wel     = !((state == CAS) && lat_write);

endmodule

// File: tb/tb_dram_seq.sv
// Directed bench for dram_seq: one instance with default parameters and a
// second with PAGE=0 sharing the same stimulus.
module tb_dram_seq;

   logic       clk = 1'b0, res = 1'b1, req = 1'b0, write = 1'b0, bank = 1'b0;
   logic [8:0] row = '0;
   logic       ack, busy, roffl, allonl, alloffl, casl, colsel, wel;
   logic [1:0] on;
   logic       p0_ack, p0_busy, p0_roffl, p0_allonl, p0_alloffl, p0_casl, p0_colsel, p0_wel;
   logic [1:0] p0_on;

   dram_seq u_dut (
      .clk(clk), .res(res), .req(req), .write(write), .bank(bank), .row(row),
      .ack(ack), .busy(busy), .on(on), .roffl(roffl), .allonl(allonl),
      .alloffl(alloffl), .casl(casl), .colsel(colsel), .wel(wel));

   dram_seq #(.PAGE(1'b0)) u_dut0 (
      .clk(clk), .res(res), .req(req), .write(write), .bank(bank), .row(row),
      .ack(p0_ack), .busy(p0_busy), .on(p0_on), .roffl(p0_roffl), .allonl(p0_allonl),
      .alloffl(p0_alloffl), .casl(p0_casl), .colsel(p0_colsel), .wel(p0_wel));

   always #5 clk = ~clk;

   // cycles since the last reset edge (equals the DUT refresh counter phase)
   int cyc;
   always @(posedge clk) begin
      if (res) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   logic [1:0] t_on    [0:19];
   logic       t_casl  [0:19];
   logic       t_wel   [0:19];
   logic       t_roffl [0:19];
   logic       t_ack   [0:19];
   logic       t_busy  [0:19];
   logic       t_allon [0:19];
   logic       t_alloff[0:19];
   logic       t_colsel[0:19];
   logic       q_ack   [0:19];
   logic       q_roffl [0:19];

   task automatic sample(input int i);
      t_on[i]     = on;      t_casl[i]   = casl;   t_wel[i]   = wel;
      t_roffl[i]  = roffl;   t_ack[i]    = ack;    t_busy[i]  = busy;
      t_allon[i]  = allonl;  t_alloff[i] = alloffl; t_colsel[i] = colsel;
      q_ack[i]    = p0_ack;  q_roffl[i]  = p0_roffl;
   endtask

   // Called at a negedge; that cycle is k (index 0). req drops once ack is seen.
   task automatic run(input logic w, input logic b, input logic [8:0] r, input int len);
      write = w; bank = b; row = r; req = 1'b1;
      sample(0);
      for (int i = 1; i <= len; i++) begin
         @(negedge clk);
         sample(i);
         if (ack) req = 1'b0;
      end
      req = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_busy",   busy,    0);
      chk("rst_ack",    ack,     0);
      chk("rst_on",     on,      0);
      chk("rst_strobes", {roffl, allonl, alloffl, casl, colsel, wel}, 6'b111101);
      res = 1'b0;

      // closed-page read
      run(1'b0, 1'b0, 9'h012, 6);
      chk("rd_on1",     t_on[1],     2'b01);
      chk("rd_casl3",   t_casl[3],   1);
      chk("rd_casl4",   t_casl[4],   0);
      chk("rd_casl5",   t_casl[5],   0);
      chk("rd_casl6",   t_casl[6],   1);
      chk("rd_colsel4", t_colsel[4], 1);
      chk("rd_ack4",    t_ack[4],    0);
      chk("rd_ack5",    t_ack[5],    1);
      chk("rd_busy6",   t_busy[6],   0);
      n = 0;
      for (int i = 0; i <= 6; i++) if (!t_wel[i]) n++;
      chk("rd_wel_low", n, 0);

      // page hit write
      run(1'b1, 1'b0, 9'h012, 3);
      n = 0;
      for (int i = 0; i <= 3; i++) if (t_on[i] != 2'b00) n++;
      chk("hit_no_on", n, 0);
      chk("hit_wel1",  t_wel[1], 0);
      chk("hit_wel2",  t_wel[2], 0);
      chk("hit_wel3",  t_wel[3], 1);
      chk("hit_ack2",  t_ack[2], 1);

      // page miss, other bank
      run(1'b0, 1'b1, 9'h012, 8);
      chk("miss_roffl1", t_roffl[1], 0);
      chk("miss_roffl2", t_roffl[2], 1);
      chk("miss_on3",    t_on[3],    2'b10);
      chk("miss_ack6",   t_ack[6],   0);
      chk("miss_ack7",   t_ack[7],   1);

      // refresh pending when req arrives, bank 1 page open
      while (cyc < 256) @(negedge clk);
      run(1'b0, 1'b0, 9'h034, 16);
      chk("ref_roffl1",  t_roffl[1],  0);
      chk("ref_casl2",   t_casl[2],   1);
      chk("ref_casl3",   t_casl[3],   0);
      chk("ref_allon3",  t_allon[3],  1);
      chk("ref_allon4",  t_allon[4],  0);
      chk("ref_alloff7", t_alloff[7], 0);
      chk("ref_casl7",   t_casl[7],   1);
      chk("ref_busy9",   t_busy[9],   0);
      chk("ref_on10",    t_on[10],    2'b01);
      chk("ref_ack14",   t_ack[14],   1);

      // one refresh per REFDIV window
      n = 0;
      repeat (256) begin
         @(negedge clk);
         if (!allonl) n++;
      end
      chk("ref_once", n, 1);

      // reset during RCD aborts the access
      write = 1'b0; bank = 1'b0; row = 9'h055; req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("abort_in_rcd", {busy, casl, colsel}, 3'b110);
      res = 1'b1; req = 1'b0;
      @(negedge clk);
      chk("abort_rst", {busy, casl, on}, 4'b0100);
      res = 1'b0;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (ack || busy) n++;
      end
      chk("abort_no_ack", n, 0);

      // fresh access after reset, both page modes
      run(1'b0, 1'b0, 9'h055, 6);
      chk("post_on1",   t_on[1],    2'b01);
      chk("post_ack5",  t_ack[5],   1);
      chk("p0_ack5",    q_ack[5],   1);
      chk("p0_roffl6",  q_roffl[6], 0);
      chk("p0_roffl5",  q_roffl[5], 1);
      repeat (3) @(negedge clk);
      run(1'b1, 1'b1, 9'h0aa, 8);
      chk("pm_roffl1",  t_roffl[1], 0);
      chk("pm_ack7",    t_ack[7],   1);
      chk("p0b_roffl1", q_roffl[1], 1);
      chk("p0b_ack5",   q_ack[5],   1);
      chk("p0b_roffl6", q_roffl[6], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
